// File: rtl/rsp_encode_pkg.sv
// rtl/rsp_encode_pkg.sv - constants and FSM encoding shared by the SDRAM/UART command and response blocks
package rsp_encode_pkg;

    // Command decoder framing bytes
    localparam logic [7:0] CMD_WR_HEAD = 8'h55;
    localparam logic [7:0] CMD_RD_HEAD = 8'hAA;

    // Response encoder defaults
    localparam logic [7:0]  RSP_HEAD_DEF  = 8'hAA;
    localparam int unsigned BURST_LEN_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEAD    = 3'd1,
        ST_POP     = 3'd2,
        ST_LATCH   = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } rsp_state_t;

endpackage

// File: rtl/rsp_encode.sv
// rtl/rsp_encode.sv - read-response encoder: header plus burst bytes from the read FIFO to uart_tx
module rsp_encode
    import rsp_encode_pkg::*;
#(
    parameter int unsigned BURST_LEN = BURST_LEN_DEF,
    parameter logic [7:0]  RSP_HEAD  = RSP_HEAD_DEF,
    parameter bit          HEAD_EN   = 1'b1
) (
    input  logic       s_clk,
    input  logic       s_rst_n,
    input  logic       rd_done,
    input  logic       rfifo_empty,
    output logic       rfifo_rd_en,
    input  logic [7:0] rfifo_rd_data,
    output logic       tx_trig,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       rsp_busy
);

    localparam logic [7:0] LAST_CNT = BURST_LEN[7:0];

    rsp_state_t state, state_nxt;
    logic [7:0] byte_cnt, byte_cnt_nxt;
    logic [7:0] tx_data_nxt;
    logic       pend, pend_nxt;
    // Set after the first WAIT_TX cycle; tx_busy is only trusted once this is high
    logic       wait_armed, wait_armed_nxt;

    // State and datapath registers
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state      <= ST_IDLE;
            byte_cnt   <= 8'd0;
            pend       <= 1'b0;
            tx_data    <= 8'd0;
            wait_armed <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= byte_cnt_nxt;
            pend       <= pend_nxt;
            tx_data    <= tx_data_nxt;
            wait_armed <= wait_armed_nxt;
        end
    end

    // Next-state, pending-request capture and strobe decode
    always_comb begin
        state_nxt      = state;
        byte_cnt_nxt   = byte_cnt;
        pend_nxt       = pend;
        tx_data_nxt    = tx_data;
        wait_armed_nxt = 1'b0;
        tx_trig        = 1'b0;
        rfifo_rd_en    = 1'b0;
        rsp_busy       = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (rd_done || pend) begin
                    state_nxt    = HEAD_EN ? ST_HEAD : ST_POP;
                    byte_cnt_nxt = 8'd0;
                    // A rd_done arriving while a pending request is consumed must not be lost
                    pend_nxt     = pend && rd_done;
                    // Header is loaded on entry so tx_data is already valid under tx_trig
                    if (HEAD_EN) begin
                        tx_data_nxt = RSP_HEAD;
                    end
                end
            end
            ST_HEAD: begin
                tx_trig   = 1'b1;
                state_nxt = ST_WAIT_TX;
            end
            ST_POP: begin
                if (!rfifo_empty) begin
                    rfifo_rd_en = 1'b1;
                    state_nxt   = ST_LATCH;
                end
            end
            ST_LATCH: begin
                tx_data_nxt = rfifo_rd_data;
                state_nxt   = ST_SEND;
            end
            ST_SEND: begin
                tx_trig      = 1'b1;
                byte_cnt_nxt = byte_cnt + 8'd1;
                state_nxt    = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                wait_armed_nxt = 1'b1;
                if (wait_armed && !tx_busy) begin
                    state_nxt = (byte_cnt == LAST_CNT) ? ST_IDLE : ST_POP;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // One-deep pending slot; further requests while it is full are dropped
        if (state != ST_IDLE && rd_done) begin
            pend_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_rsp_encode.sv
// tb/tb_rsp_encode.sv - bench for rsp_encode with behavioural read FIFO and uart_tx models
module tb_rsp_encode;

    localparam logic [7:0] HDR       = 8'hAA;
    localparam int         BUSY_CYC  = 10;
    localparam int         LIMIT     = 3000;

    logic       s_clk;
    logic       s_rst_n;
    logic [1:0] rd_done;
    logic [1:0] rfifo_empty;
    logic [1:0] rfifo_rd_en;
    logic [7:0] rfifo_rd_data [2];
    logic [1:0] tx_trig;
    logic [7:0] tx_data [2];
    logic [1:0] tx_busy;
    logic [1:0] rsp_busy;

    // Instance 0 sends the header, instance 1 sends data only
    rsp_encode #(.HEAD_EN(1'b1)) u_dut0 (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .rd_done(rd_done[0]),
        .rfifo_empty(rfifo_empty[0]), .rfifo_rd_en(rfifo_rd_en[0]), .rfifo_rd_data(rfifo_rd_data[0]),
        .tx_trig(tx_trig[0]), .tx_data(tx_data[0]), .tx_busy(tx_busy[0]), .rsp_busy(rsp_busy[0])
    );

    rsp_encode #(.HEAD_EN(1'b0)) u_dut1 (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .rd_done(rd_done[1]),
        .rfifo_empty(rfifo_empty[1]), .rfifo_rd_en(rfifo_rd_en[1]), .rfifo_rd_data(rfifo_rd_data[1]),
        .tx_trig(tx_trig[1]), .tx_data(tx_data[1]), .tx_busy(tx_busy[1]), .rsp_busy(rsp_busy[1])
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    // Behavioural models: FIFO storage written by the stimulus, counters kept by the monitor
    logic [7:0] fifo_mem [2][256];
    int         wr_ptr [2];
    int         rd_ptr [2];
    int         busy_cnt [2];
    logic [7:0] log_mem [2][1024];
    int         log_cnt [2];
    int         trig_cnt [2];
    int         pop_cnt [2];
    int         viol [2];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            rfifo_empty[g] = (rd_ptr[g] == wr_ptr[g]);
        end
    end

    // Non-FWFT FIFO, uart_tx busy model, byte logger and protocol checker
    always @(posedge s_clk) begin
        for (int g = 0; g < 2; g++) begin
            if (tx_trig[g] && tx_busy[g]) viol[g] <= viol[g] + 1;
            if (rfifo_rd_en[g] && rfifo_empty[g]) viol[g] <= viol[g] + 1;
            if (!s_rst_n) begin
                rd_ptr[g]   <= wr_ptr[g];
                busy_cnt[g] <= 0;
                tx_busy[g]  <= 1'b0;
            end else begin
                if (rfifo_rd_en[g] && !rfifo_empty[g]) begin
                    rfifo_rd_data[g] <= fifo_mem[g][rd_ptr[g] % 256];
                    rd_ptr[g]        <= rd_ptr[g] + 1;
                end
                if (rfifo_rd_en[g]) pop_cnt[g] <= pop_cnt[g] + 1;
                if (tx_trig[g]) begin
                    log_mem[g][log_cnt[g] % 1024] <= tx_data[g];
                    log_cnt[g]  <= log_cnt[g] + 1;
                    trig_cnt[g] <= trig_cnt[g] + 1;
                    busy_cnt[g] <= BUSY_CYC;
                    tx_busy[g]  <= 1'b1;
                end else if (busy_cnt[g] > 1) begin
                    busy_cnt[g] <= busy_cnt[g] - 1;
                end else begin
                    busy_cnt[g] <= 0;
                    tx_busy[g]  <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int g, input logic [7:0] b);
        fifo_mem[g][wr_ptr[g] % 256] = b;
        wr_ptr[g] = wr_ptr[g] + 1;
    endtask

    // Reference: a response is [header] followed by the next burst bytes in FIFO order
    task automatic model_rsp(input int g, input logic [31:0] d);
        if (g == 0) exp_q.push_back(HDR);
        for (int i = 0; i < 4; i++) exp_q.push_back(d[31 - 8*i -: 8]);
    endtask

    task automatic check_stream(input string name, input int g, input int base);
        check({name, "_len"}, log_cnt[g] - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), int'(log_mem[g][(base + i) % 1024]), int'(exp_q[i]));
        end
    endtask

    // One response: optionally preload, pulse rd_done, write late data after 'delay' cycles
    task automatic run_rsp(input int g, input logic [31:0] d, input int delay,
                           output int lat, output int stall_pops);
        int base_pop;
        bit done;
        base_pop   = pop_cnt[g];
        done       = 1'b0;
        lat        = -1;
        stall_pops = 0;
        if (delay == 0) for (int i = 0; i < 4; i++) push(g, d[31 - 8*i -: 8]);
        @(negedge s_clk);
        rd_done[g] = 1'b1;
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            @(negedge s_clk);
            rd_done[g] = 1'b0;
            if (lat < 0 && tx_trig[g]) lat = cyc;
            if (cyc == delay) begin
                stall_pops = pop_cnt[g] - base_pop;
                for (int i = 0; i < 4; i++) push(g, d[31 - 8*i -: 8]);
            end
            if (cyc > delay && !rsp_busy[g]) begin
                done = 1'b1;
                break;
            end
        end
        check("rsp_done", int'(done), 1);
    endtask

    typedef struct {
        int          dut;
        logic [31:0] data;
        int          delay;
        int          exp_trigs;
        int          exp_pops;
        int          exp_lat;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int lat, stall, base_log, base_trig, base_pop, idle;
        bit done;
        logic [31:0] rd;

        vecs[0] = '{dut: 0, data: 32'h11223344, delay: 0,  exp_trigs: 5, exp_pops: 4, exp_lat: -1};
        vecs[1] = '{dut: 1, data: 32'h11223344, delay: 0,  exp_trigs: 4, exp_pops: 4, exp_lat: 3};
        vecs[2] = '{dut: 0, data: 32'h5AA50FF0, delay: 50, exp_trigs: 5, exp_pops: 4, exp_lat: -1};
        vecs[3] = '{dut: 1, data: 32'hDEADBEEF, delay: 20, exp_trigs: 4, exp_pops: 4, exp_lat: -1};

        for (int g = 0; g < 2; g++) begin
            wr_ptr[g] = 0; log_cnt[g] = 0; trig_cnt[g] = 0; pop_cnt[g] = 0; viol[g] = 0;
        end
        s_rst_n = 1'b0;
        rd_done = 2'b00;
        repeat (3) @(negedge s_clk);
        check("rst_strobes", int'({rsp_busy, tx_trig, rfifo_rd_en}), 0);
        check("rst_tx_data", int'({tx_data[0], tx_data[1]}), 0);
        s_rst_n = 1'b1;
        repeat (2) @(negedge s_clk);

        // Table-driven single responses
        for (int v = 0; v < 4; v++) begin
            int g;
            g = vecs[v].dut;
            base_log  = log_cnt[g];
            base_trig = trig_cnt[g];
            base_pop  = pop_cnt[g];
            exp_q.delete();
            model_rsp(g, vecs[v].data);
            run_rsp(g, vecs[v].data, vecs[v].delay, lat, stall);
            check($sformatf("v%0d_trigs", v), trig_cnt[g] - base_trig, vecs[v].exp_trigs);
            check($sformatf("v%0d_pops", v), pop_cnt[g] - base_pop, vecs[v].exp_pops);
            check($sformatf("v%0d_busy_low", v), int'(tx_busy[g]), 0);
            if (vecs[v].exp_lat >= 0) check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            if (vecs[v].delay > 0) check($sformatf("v%0d_stall_pops", v), stall, 0);
            check_stream($sformatf("v%0d", v), g, base_log);
            repeat (3) @(negedge s_clk);
        end

        // Second rd_done during byte 2 -> pending response served after one IDLE cycle
        base_log  = log_cnt[0];
        base_trig = trig_cnt[0];
        base_pop  = pop_cnt[0];
        exp_q.delete();
        model_rsp(0, 32'h01020304);
        model_rsp(0, 32'h05060708);
        for (int i = 1; i <= 8; i++) push(0, 8'(i));
        @(negedge s_clk);
        rd_done[0] = 1'b1;
        done = 1'b0;
        for (int cyc = 0; cyc < LIMIT; cyc++) begin
            @(negedge s_clk);
            rd_done[0] = 1'b0;
            if (trig_cnt[0] - base_trig == 2) begin
                done = 1'b1;
                break;
            end
        end
        check("pend_reach_byte2", int'(done), 1);
        repeat (3) @(negedge s_clk);
        rd_done[0] = 1'b1;
        idle = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < LIMIT; cyc++) begin
            @(negedge s_clk);
            rd_done[0] = 1'b0;
            if (!rsp_busy[0]) begin
                if (trig_cnt[0] - base_trig == 10) begin
                    done = 1'b1;
                    break;
                end
                idle++;
            end
        end
        check("pend_done", int'(done), 1);
        check("pend_idle_gap", idle, 1);
        check("pend_trigs", trig_cnt[0] - base_trig, 10);
        check("pend_pops", pop_cnt[0] - base_pop, 8);
        check_stream("pend", 0, base_log);
        repeat (3) @(negedge s_clk);

        // Asynchronous reset during byte 3, then a clean response
        base_trig = trig_cnt[0];
        for (int i = 0; i < 4; i++) push(0, 8'(8'h30 + i));
        @(negedge s_clk);
        rd_done[0] = 1'b1;
        done = 1'b0;
        for (int cyc = 0; cyc < LIMIT; cyc++) begin
            @(negedge s_clk);
            rd_done[0] = 1'b0;
            if (trig_cnt[0] - base_trig == 3) begin
                done = 1'b1;
                break;
            end
        end
        check("rst_reach_byte3", int'(done), 1);
        repeat (2) @(negedge s_clk);
        #1 s_rst_n = 1'b0;
        #1;
        check("async_rst_strobes", int'({rsp_busy, tx_trig, rfifo_rd_en}), 0);
        check("async_rst_tx_data", int'({tx_data[0], tx_data[1]}), 0);
        repeat (2) @(negedge s_clk);
        s_rst_n = 1'b1;
        repeat (2) @(negedge s_clk);
        check("rst_fifo_flushed", int'(rfifo_empty[0]), 1);
        base_log = log_cnt[0];
        exp_q.delete();
        model_rsp(0, 32'hCAFEBABE);
        run_rsp(0, 32'hCAFEBABE, 0, lat, stall);
        check_stream("post_rst", 0, base_log);

        // Randomized responses on both instances against the reference stream
        for (int g = 0; g < 2; g++) begin
            base_log  = log_cnt[g];
            base_pop  = pop_cnt[g];
            exp_q.delete();
            for (int it = 0; it < 6; it++) begin
                int dly;
                rd  = $urandom;
                dly = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : 0;
                model_rsp(g, rd);
                run_rsp(g, rd, dly, lat, stall);
                check($sformatf("rnd%0d_%0d_stall_pops", g, it), stall, 0);
                repeat ($urandom_range(1, 4)) @(negedge s_clk);
            end
            check($sformatf("rnd%0d_pops", g), pop_cnt[g] - base_pop, 24);
            check_stream($sformatf("rnd%0d", g), g, base_log);
        end

        check("proto_viol0", viol[0], 0);
        check("proto_viol1", viol[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
